// File: rtl/halfword_packer_pkg.sv
// Package pack_pkg: types and defaults shared by the halfword packer and the
// neighbouring FSM stages.
//   state_t        : packer FSM state, 8-bit encoding shared with the other
//                    FSM stages so debug tooling reads all stages the same way
//   PAD_DEFAULT    : fill value for the lower half when a lone halfword is flushed
//   COUNT_W_DEFAULT: default width of the delivered-word counter
package pack_pkg;

  typedef enum logic [7:0] {
    S_EMPTY = 8'd0,   // no pending data
    S_HALF  = 8'd1,   // upper half latched, waiting for the lower half
    S_FULL  = 8'd2    // packed word held on outData with outValid=1
  } state_t;

  localparam logic [15:0] PAD_DEFAULT     = 16'h0000;
  localparam int          COUNT_W_DEFAULT = 16;

endpackage

// File: rtl/halfword_packer_if.sv
// Bus bundle for the halfword packer.
//   inData/inValid/inReady : halfword stream from the upstream stage
//   flush                  : close out a dangling halfword with padding
//   outData/outValid/outReady : packed 32-bit word stream to the consumer
//   wordCount              : wrapping count of words taken by the consumer
//
// Handshake rule for both streams: a transfer happens at a rising clock edge
// exactly when valid and ready are both high. A source holding valid=1 keeps
// its data stable until the transfer; valid never waits on ready.
//
// Modports: master = the environment around the packer, slave = the packer.
interface halfword_packer_if #(
  parameter int COUNT_W = 16
);
  logic [15:0]        inData;
  logic               inValid;
  logic               inReady;
  logic               flush;
  logic [31:0]        outData;
  logic               outValid;
  logic               outReady;
  logic [COUNT_W-1:0] wordCount;

  modport master (
    output inData, inValid, flush, outReady,
    input  inReady, outData, outValid, wordCount
  );

  modport slave (
    input  inData, inValid, flush, outReady,
    output inReady, outData, outValid, wordCount
  );
endinterface

// File: rtl/halfword_packer.sv
// halfword_packer: packs consecutive 16-bit halfwords into 32-bit words.
// The first halfword of a pair lands in outData[31:16], the second in [15:0].
// A flush while only the upper half is held completes the word with PAD.
// One output holding register; while the consumer takes every word the
// stage accepts one halfword per cycle.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous, active-high
//   bus       : halfword_packer_if.slave (both streams, flush, wordCount)
//   dbg_state : current FSM state, for observation only
module halfword_packer
  import pack_pkg::*;
#(
  parameter logic [15:0] PAD     = PAD_DEFAULT,
  parameter int          COUNT_W = COUNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  halfword_packer_if.slave     bus,
  output state_t               dbg_state
);

  state_t             state_q, state_d;
  logic [31:0]        data_q, data_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic in_ready;
  logic out_valid;
  logic in_xfer;
  logic out_xfer;

  // outValid comes straight from the state register, so it never depends on
  // outReady. inReady may look through to outReady: a held word that leaves
  // this cycle frees the upper half for the incoming halfword.
  assign out_valid = (state_q == S_FULL);
  assign in_ready  = !reset && ((state_q != S_FULL) || bus.outReady);
  assign in_xfer   = bus.inValid && in_ready;
  assign out_xfer  = out_valid && bus.outReady;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q + {{(COUNT_W-1){1'b0}}, out_xfer};

    case (state_q)
      S_EMPTY: begin
        if (in_xfer) begin
          data_d[31:16] = bus.inData;
          state_d       = S_HALF;
        end
      end
      S_HALF: begin
        // A real halfword always wins over a simultaneous flush.
        if (in_xfer) begin
          data_d[15:0] = bus.inData;
          state_d      = S_FULL;
        end else if (bus.flush && !bus.inValid) begin
          data_d[15:0] = PAD;
          state_d      = S_FULL;
        end
      end
      S_FULL: begin
        if (out_xfer) begin
          if (in_xfer) begin
            data_d[31:16] = bus.inData;
            state_d       = S_HALF;
          end else begin
            state_d = S_EMPTY;
          end
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
      data_q  <= 32'h0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign bus.inReady   = in_ready;
  assign bus.outData   = data_q;
  assign bus.outValid  = out_valid;
  assign bus.wordCount = count_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/halfword_packer.md
# halfword_packer

Downstream stage that consumes the 16-bit halfword stream produced by the byte-doubling FSM stage and packs consecutive halfword pairs into 32-bit words for the wide datapath. The first accepted halfword occupies the upper half of the output word. Valid/ready handshakes apply on both sides, with a single output holding register sustaining one halfword per cycle. A flush input closes out a dangling half-word with padding. A wrapping counter reports delivered words.

## Interface
- PAD, 16'h0000, fill value for the lower half on flush
- COUNT_W, 16, width of delivered-word counter
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- inData  in  16  halfword from upstream stage
- inValid  in  1  inData valid
- inReady  out  1  stage accepts inData this cycle
- flush  in  1  emit pending lone halfword padded with PAD
- outData  out  32  packed word, first halfword in [31:16]
- outValid  out  1  outData valid
- outReady  in  1  consumer accepts outData this cycle
- wordCount  out  COUNT_W  count of words accepted by consumer, wraps

## Operation
- Input transfer: inValid & inReady at a rising edge. Output transfer: outValid & outReady at a rising edge.
- States:
  - S_EMPTY (0): no pending data.
  - S_HALF (1): upper half latched.
  - S_FULL (2): outData held with outValid=1.
- inReady = (state != S_FULL) | outReady. This is combinational from outReady. It is forced to 0 while reset is asserted.
- S_EMPTY:
  - Input transfer -> latch inData into outData[31:16] -> S_HALF.
  - flush is ignored.
- S_HALF:
  - Input transfer -> outData[15:0] <= inData -> S_FULL. Any simultaneous flush is ignored.
  - flush & !inValid -> outData[15:0] <= PAD -> S_FULL.
- S_FULL:
  - outValid=1. outData is stable until an output transfer occurs.
  - Output transfer without input transfer -> S_EMPTY.
  - Output transfer with input transfer -> outData[31:16] <= inData -> S_HALF, giving back-to-back throughput.
  - flush is ignored.
- wordCount increments by 1 on every output transfer and wraps from 2^COUNT_W-1 to 0.
- Halfword order is strictly preserved. No halfword is dropped or duplicated.
- The outData lower half is don't-care outside S_FULL; the bench checks it only when outValid=1.

## Timing
- Reset values: state=S_EMPTY, outData=0, outValid=0, wordCount=0. inReady=0 during reset and 1 on the first cycle after deassertion.
- Reset asserted mid-operation discards the pending half and any held word immediately (asynchronous), with no output transfer.
- Latency: outValid rises on the edge that accepts the second halfword (or the flush edge) and is visible the following cycle.
- Throughput: one halfword per cycle while outReady=1, i.e. one 32-bit word per 2 cycles.
- Backpressure: with outReady=0 in S_FULL, inReady=0 and outData/outValid remain unchanged indefinitely.
- outValid does not depend combinationally on outReady. Once asserted, it stays high until an output transfer.

## Structure
- Shared package pack_pkg holds:
  - state typedef: S_EMPTY=0, S_HALF=1, S_FULL=2, with 8-bit state encoding to match the existing FSM stages.
  - default PAD constant.
- Single module. No sub-module is natural; the counter and FSM are each a few lines and share the transfer strobes.

## Test plan
- Reset then inData 16'hA5A5, 16'h3C3C on consecutive cycles with outReady=1 -> outData=32'hA5A53C3C, outValid one cycle, wordCount=1.
- Continuous stream 16'h0001..16'h0008 with outReady=1 -> four words 0x00010002, 0x00030004, 0x00050006, 0x00070008, inReady never low, wordCount=4.
- Word 0x11112222 held with outReady=0 for 5 cycles and inValid=1 -> inReady=0, outData stable. On release, the next halfword is accepted in the same cycle.
- inData 16'hBEEF then flush with inValid=0 -> outData=32'hBEEF0000. Flush in S_EMPTY or S_FULL produces no effect.
- Assert reset while in S_HALF holding 16'h1234 -> outValid=0, wordCount=0. The next pair 16'h5555, 16'h6666 yields 32'h55556666.
- COUNT_W=4, 17 words -> wordCount wraps to 1.
